dmem_store_buffer: RTL and testbench
====================================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cpu_we  input  1  MEM-stage store request (CPU MemWrite).
REQ-005 SHALL have port cpu_re  input  1  MEM-stage load request.
REQ-006 SHALL have port cpu_addr  input  32  MEM-stage byte address (CPU aluout).
REQ-007 SHALL have port cpu_wdata  input  32  store data (CPU writedata).
REQ-008 SHALL have port cpu_rdata  output  32  load data returned to CPU (CPU readdata).
REQ-009 SHALL have port sb_stall  output  1  buffer full with a store pending; CPU freezes its pipeline.
REQ-010 SHALL have port sb_count  output  4  number of valid entries, 0..DEPTH.
REQ-011 SHALL have port mem_req  output  1  drain write request to data RAM.
REQ-012 SHALL have port mem_waddr  output  32  drain write address (head entry).
REQ-013 SHALL have port mem_wdata  output  32  drain write data (head entry).
REQ-014 SHALL have port mem_ack  input  1  RAM accepted the current drain write.
REQ-015 SHALL have port mem_raddr  output  32  RAM asynchronous read address, equal to cpu_addr.
REQ-016 SHALL have port mem_rdata  input  32  RAM asynchronous read data.

Function
REQ-017 SHALL store entries as {addr[31:2], data[31:0]} in a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-018 SHALL enqueue cpu_addr/cpu_wdata at the tail on an edge where cpu_we=1 and sb_count<DEPTH.
REQ-019 SHALL drive sb_stall=1 combinationally when cpu_we=1 and sb_count==DEPTH; the store is not accepted and the CPU holds it.
REQ-020 SHALL evaluate fullness on the registered sb_count only; a same-cycle mem_ack does not release a full-buffer stall.
REQ-021 SHALL drive mem_req=1 whenever sb_count>0, with mem_waddr={head.addr,2'b00} and mem_wdata=head.data.
REQ-022 SHALL hold mem_req, mem_waddr, mem_wdata stable until mem_ack is sampled high at an edge; mem_ack with mem_req=0 SHALL be ignored.
REQ-023 SHALL pop the head on an edge where mem_req=1 and mem_ack=1; at most one pop per cycle, so the RAM sees writes in program order.
REQ-024 SHALL, on an edge with both enqueue and pop, leave sb_count unchanged and advance both pointers.
REQ-025 SHALL drive cpu_rdata combinationally: data of the youngest valid entry with addr==cpu_addr[31:2], else mem_rdata.
REQ-026 SHALL include the head entry in forwarding even in the cycle it is being acked.
REQ-027 SHALL treat address match as full-word only; byte/halfword stores are not supported in this block.
REQ-028 SHALL ignore cpu_re when cpu_we=1 (cpu_rdata unspecified); cpu_re otherwise only qualifies the load, cpu_rdata is valid whenever cpu_re=1.
REQ-029 SHALL keep mem_raddr=cpu_addr at all times, independent of buffer state.
REQ-030 SHALL have a single-cycle store latency from the CPU side: accepted stores retire in the MEM cycle and are visible to loads in the next cycle.

Reset
REQ-031 SHALL, on an edge with rst=1, set head=tail=0, sb_count=0; entry contents don't care.
REQ-032 SHALL drive mem_req=0 and sb_stall=0 from the first cycle after reset until the next accepted store.
REQ-033 SHALL discard all pending entries when reset asserts mid-drain, including an entry acked in the reset cycle; no further write is presented.
REQ-034 SHALL give rst priority over cpu_we and mem_ack in the same cycle.

Verification
REQ-035 Single store: sw 0x0000_00A5 -> addr 0x10, mem_ack=0 for 3 cycles then 1 -> mem_req high 4 cycles, addr/data stable, sb_count 1 -> 0 after ack edge.
REQ-036 Fill: 5 back-to-back stores, mem_ack=0, DEPTH=4 -> sb_count 4, sb_stall=1 on 5th; release ack one cycle -> 5th enqueued next cycle, RAM receives addresses in issue order.
REQ-037 Forwarding: sw 0x11 to 0x20, sw 0x22 to 0x20, lw 0x20 with no ack -> cpu_rdata=0x22; lw 0x24 -> cpu_rdata=mem_rdata.
REQ-038 Simultaneous enqueue+pop at sb_count=2 -> sb_count stays 2, pointers wrap correctly after 8 such cycles, data order preserved.
REQ-039 Reset mid-drain: 3 entries pending, assert rst one cycle -> sb_count=0, mem_req=0 next cycle, no further RAM writes.
REQ-040 Ack without request: mem_ack=1 with empty buffer -> sb_count stays 0, no underflow, pointers unchanged.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// dmem_store_buffer
//
// Posted-write buffer between the CPU MEM stage and the data RAM. Stores retire
// from the CPU in one cycle into a small circular FIFO. The FIFO drains to the
// RAM one word at a time, in program order, under a req/ack handshake. Loads
// are forwarded from the youngest matching buffered store. Otherwise they read
// the RAM's asynchronous port.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   cpu_we     in   MEM-stage store request
//   cpu_re     in   MEM-stage load request (qualifier only)
//   cpu_addr   in   [31:0] byte address
//   cpu_wdata  in   [31:0] store data
//   cpu_rdata  out  [31:0] load data (forwarded or RAM)
//   sb_stall   out  store pending while buffer full
//   sb_count   out  [3:0] valid entries, 0..DEPTH
//   mem_req    out  drain write request (head entry valid)
//   mem_waddr  out  [31:0] drain write address
//   mem_wdata  out  [31:0] drain write data
//   mem_ack    in   RAM accepted the drain write
//   mem_raddr  out  [31:0] RAM read address (always cpu_addr)
//   mem_rdata  in   [31:0] RAM read data
// -----------------------------------------------------------------------------
module dmem_store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        sb_stall,
   output logic [3:0]  sb_count,
   output logic        mem_req,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   output logic [31:0] mem_raddr,
   input  logic [31:0] mem_rdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   // Entry storage. Forwarding needs every entry in parallel, so these are
   // plain registers and not a RAM.
   logic [29:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [3:0]       count_q, count_d;

   logic             full;
   logic             empty;
   logic             enq;
   logic             pop;

   // Fullness is judged on the registered count only. An ack in the same
   // cycle frees a slot for the next cycle and does not release this stall.
   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == 4'd0);
   assign enq   = cpu_we && !full;
   assign pop   = !empty && mem_ack;

   assign sb_stall  = cpu_we && full;
   assign sb_count  = count_q;
   assign mem_req   = !empty;
   assign mem_waddr = {addr_q[head_q], 2'b00};
   assign mem_wdata = data_q[head_q];
   assign mem_raddr = cpu_addr;

   // cpu_re only qualifies the load on the CPU side. The byte offset is not
   // part of the word-granular match.
   logic unused_bits;
   assign unused_bits = cpu_re ^ cpu_addr[1] ^ cpu_addr[0];

   // -------------------------------------------------------------------------
   // Pointer and count next-state
   // -------------------------------------------------------------------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (enq) begin
         tail_d = tail_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (enq && !pop) begin
         count_d = count_q + 4'd1;
      end else if (pop && !enq) begin
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // -------------------------------------------------------------------------
   // Entry write: one slot per generate instance, selected by the tail pointer
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (!rst && enq && (tail_q == PTR_W'(gi))) begin
               addr_q[gi] <= cpu_addr[31:2];
               data_q[gi] <= cpu_wdata;
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Load forwarding. Walk the entries from oldest (head) to youngest. A later
   // match overrides an earlier one, so the youngest matching store wins. The
   // head stays eligible in the cycle it is acked because the pop takes effect
   // only at the edge.
   // -------------------------------------------------------------------------
   logic [PTR_W-1:0] fwd_idx;

   always_comb begin
      cpu_rdata = mem_rdata;
      fwd_idx   = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if ((4'(i) < count_q) && (addr_q[fwd_idx] == cpu_addr[31:2])) begin
            cpu_rdata = data_q[fwd_idx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        cpu_we;
   logic        cpu_re;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        sb_stall;
   logic [3:0]  sb_count;
   logic        mem_req;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;

   dmem_store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_we    (cpu_we),
      .cpu_re    (cpu_re),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .sb_stall  (sb_stall),
      .sb_count  (sb_count),
      .mem_req   (mem_req),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of pending stores, oldest at index 0.
   logic [31:0] q_addr [$];
   logic [31:0] q_data [$];
   // Writes the RAM should receive (from the model) and writes the DUT made.
   logic [63:0] exp_log [$];
   logic [63:0] dut_log [$];

   int n_assert = 0;
   int n_fail   = 0;
   int step_no  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] ram);
      logic [31:0] r;
      r = ram;
      for (int i = 0; i < q_addr.size(); i++) begin
         if (q_addr[i][31:2] == a[31:2]) r = q_data[i];
      end
      return r;
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, then apply the
   // edge to the model. The step is reported on one line.
   task automatic step(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic ack, input logic r);
      logic        exp_stall;
      logic        dut_req;
      logic [63:0] dut_wr;
      int          n;
      step_no++;
      cpu_we    = we;
      cpu_re    = re;
      cpu_addr  = a;
      cpu_wdata = wd;
      mem_ack   = ack;
      rst       = r;
      mem_rdata = $urandom;
      @(negedge clk);
      n = q_addr.size();
      exp_stall = we && (n == DEPTH);
      chk("sb_count", 32'(sb_count), 32'(n));
      chk("sb_stall", 32'(sb_stall), 32'(exp_stall));
      chk("mem_req", 32'(mem_req), 32'(n > 0));
      chk("mem_raddr", mem_raddr, a);
      if (n > 0) begin
         chk("mem_waddr", mem_waddr, {q_addr[0][31:2], 2'b00});
         chk("mem_wdata", mem_wdata, q_data[0]);
      end
      if (re && !we) chk("cpu_rdata", cpu_rdata, model_load(a, mem_rdata));
      dut_req = mem_req;
      dut_wr  = {mem_waddr, mem_wdata};
      $display("step %0d rst=%0b we=%0b re=%0b addr=%h wdata=%h ack=%0b count=%0d stall=%0b req=%0b rdata=%h",
               step_no, r, we, re, a, wd, ack, sb_count, sb_stall, mem_req, cpu_rdata);
      @(posedge clk);
      if (r) begin
         q_addr.delete();
         q_data.delete();
      end else begin
         if (dut_req && ack) dut_log.push_back(dut_wr);
         if (n > 0 && ack) begin
            exp_log.push_back({q_addr[0][31:2], 2'b00, q_data[0]});
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
         end
         if (we && n < DEPTH) begin
            q_addr.push_back(a);
            q_data.push_back(wd);
         end
      end
      #1;
   endtask

   initial begin
      logic        h_we;
      logic [31:0] h_a;
      logic [31:0] h_d;
      logic        st;

      rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0;
      cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset state, and an ack with an empty buffer.
      step(0, 0, 32'h0, 32'h0, 0, 0);
      step(0, 1, 32'h40, 32'h0, 1, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0);

      // Single store, ack held off for three cycles.
      step(1, 0, 32'h10, 32'hA5, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 32'h0, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 32'h0, 0, 0);

      // Fill with five stores; the fifth stalls until an ack frees a slot.
      for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + 32'(4*i), 32'hD0 + 32'(i), 0, 0);
      step(1, 0, 32'h110, 32'hD4, 1, 0);
      step(1, 0, 32'h110, 32'hD4, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 1, 0);

      // Forwarding of the youngest match, a miss, and a head hit during its ack.
      step(1, 0, 32'h20, 32'h11, 0, 0);
      step(1, 0, 32'h20, 32'h22, 0, 0);
      step(0, 1, 32'h20, 32'h0, 0, 0);
      step(0, 1, 32'h24, 32'h0, 0, 0);
      step(0, 1, 32'h22, 32'h0, 1, 0);
      step(0, 1, 32'h20, 32'h0, 1, 0);
      step(0, 1, 32'h20, 32'h0, 0, 0);

      // Steady push+pop at count 2 across several pointer wraps.
      step(1, 0, 32'h200, 32'h1000, 0, 0);
      step(1, 0, 32'h204, 32'h1001, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 1, 32'h208 + 32'(4*i), 32'h1002 + 32'(i), 1, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0);

      // Reset mid-drain with an ack and a store in the reset cycle.
      for (int i = 0; i < 3; i++) step(1, 0, 32'h300 + 32'(4*i), 32'h2000 + 32'(i), 0, 0);
      step(1, 0, 32'h3F0, 32'hBAD, 1, 1);
      step(0, 0, 32'h0, 32'h0, 1, 0);
      step(0, 1, 32'h300, 32'h0, 1, 0);

      // Random traffic. A stalled store is held until it is accepted.
      h_we = 1'b0; h_a = '0; h_d = '0;
      for (int i = 0; i < 400; i++) begin
         logic r;
         r = ($urandom_range(0, 79) == 0);
         if (!h_we) begin
            h_we = ($urandom_range(0, 2) != 0);
            h_a  = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            h_d  = $urandom;
         end
         st = h_we && (q_addr.size() == DEPTH) && !r;
         step(h_we, $urandom_range(0, 1) == 1, h_we ? h_a :
              32'h400 + 32'(4 * $urandom_range(0, 8)), h_d,
              $urandom_range(0, 2) == 0, r);
         if (!st) h_we = 1'b0;
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 32'h0, 32'h0, 1, 0);

      // RAM must have seen exactly the expected writes, in program order.
      chk("ram_write_count", 32'(dut_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
         chk("ram_write_addr", dut_log[i][63:32], exp_log[i][63:32]);
         chk("ram_write_data", dut_log[i][31:0], exp_log[i][31:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
